// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one word-wide memory port between the ICache and DCache
//            line engines; sequences each granted line as LINE_WORDS beats.
//            Define ARB_ROUND_ROBIN_EN for round-robin contention handling,
//            otherwise the DCache has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_req,
    input  logic [ADDR_W-1:0]             ic_addr,
    output logic                          ic_rvalid,
    output logic [DATA_W-1:0]             ic_rdata,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR_W-1:0]             dc_addr,
    input  logic [DATA_W-1:0]             dc_wdata,
    output logic                          dc_wready,
    output logic                          dc_rvalid,
    output logic [DATA_W-1:0]             dc_rdata,
    output logic                          dc_done,
    output logic [$clog2(LINE_WORDS)-1:0] xfer_idx,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int                 c_IDX_W    = $clog2(LINE_WORDS);
    localparam int                 c_OFF_W    = c_IDX_W + 2;
    localparam int                 c_LINE_W   = ADDR_W - c_OFF_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LINE_WORDS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_XFER = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_IDX_W-1:0]  r_cnt;
    logic                r_grant_d;
    logic                r_we;
    logic [c_LINE_W-1:0] r_line;
    logic                w_any_req;
    logic                w_pick_d;
    logic                w_grant;
    logic                w_unused;

    // Offset bits of the request addresses are replaced by the beat counter.
    assign w_unused  = ^{ic_addr[c_OFF_W-1:0], dc_addr[c_OFF_W-1:0]};
    assign w_any_req = ic_req | dc_req;
    assign w_grant   = (r_state == c_ST_IDLE) && w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_grant) begin
            r_last_d <= w_pick_d;
        end
    end

    // Under contention the side that did not win last time takes the port.
    assign w_pick_d = dc_req & (~ic_req | ~r_last_d);
`else
    assign w_pick_d = dc_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_grant_d <= 1'b1;
            r_we      <= 1'b0;
            r_line    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_grant_d <= w_pick_d;
                r_cnt     <= '0;
                r_we      <= w_pick_d & dc_we;
                r_line    <= w_pick_d ? dc_addr[ADDR_W-1:c_OFF_W]
                                      : ic_addr[ADDR_W-1:c_OFF_W];
            end else if ((r_state == c_ST_XFER) && mem_ack && (r_cnt != c_LAST_IDX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        ic_rvalid   = 1'b0;
        dc_rvalid   = 1'b0;
        dc_wready   = 1'b0;
        ic_done     = 1'b0;
        dc_done     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = c_ST_XFER;
                end
            end
            c_ST_XFER: begin
                mem_req  = 1'b1;
                mem_we   = r_we;
                mem_addr = {r_line, r_cnt, 2'b00};
                if (mem_ack) begin
                    ic_rvalid = ~r_grant_d;
                    dc_rvalid = r_grant_d & ~r_we;
                    dc_wready = r_grant_d & r_we;
                    if (r_cnt == c_LAST_IDX) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
            end
            c_ST_DONE: begin
                ic_done     = ~r_grant_d;
                dc_done     = r_grant_d;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Read data is a gated pass-through; validity comes from the rvalid strobes.
    assign xfer_idx  = r_cnt;
    assign mem_wdata = r_grant_d ? dc_wdata : '0;
    assign ic_rdata  = r_grant_d ? '0 : mem_rdata;
    assign dc_rdata  = r_grant_d ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Line-level reference model plus directed and random stimulus for
//            mem_port_arbiter (honours ARB_ROUND_ROBIN_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LW     = 8;
    localparam int IW     = $clog2(LW);
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              ic_req, ic_rvalid, ic_done;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              dc_req, dc_we, dc_wready, dc_rvalid, dc_done;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata, dc_rdata;
    logic [IW-1:0]     xfer_idx;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
        .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wready(dc_wready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
        .xfer_idx(xfer_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Line-level model: one line in flight, m_beats words completed so far;
    // m_beats == LW marks the completion cycle.
    bit          m_active = 1'b0;
    bit          m_side_d = 1'b0;
    bit          m_we     = 1'b0;
    bit          m_last_d = 1'b0;
    logic [31:0] m_base   = '0;
    int          m_beats  = 0;
    int          m_idle_idx = 0;

    // Requester behaviour
    bit          ic_want = 1'b0, dc_want = 1'b0;
    bit          ic_fin = 1'b0, dc_fin = 1'b0;
    logic [31:0] ic_next = '0, dc_next = '0;
    bit          dc_next_we = 1'b0;

    // Observations from the DUT for the directed literal checks
    logic [31:0] addr_log[$];
    int          idx_log[$];
    bit          done_log[$];
    int          first_req_cyc, done_cyc, ic_rv_cnt, wr_we_cnt;
    int          last_dc_beat, first_ic_beat, dc_done_cyc;
    logic        obs_req;
    logic [IW-1:0] obs_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        addr_log.delete();
        idx_log.delete();
        done_log.delete();
        first_req_cyc = -1;
        done_cyc      = -1;
        ic_rv_cnt     = 0;
        wr_we_cnt     = 0;
        last_dc_beat  = -1;
        first_ic_beat = -1;
        dc_done_cyc   = -1;
    endtask

    task automatic compare();
        bit e_req, e_done, e_ack;
        e_req  = m_active && (m_beats < LW);
        e_done = m_active && (m_beats == LW);
        e_ack  = e_req && mem_ack;
        chk("mem_req", 64'(mem_req), 64'(e_req));
        chk("mem_we", 64'(mem_we), 64'(e_req && m_we));
        if (e_req) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_base + 32'(4 * m_beats)));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_side_d ? dc_wdata : 32'h0));
            chk("xfer_idx", 64'(xfer_idx), 64'(m_beats));
        end else if (e_done) begin
            chk("xfer_idx_done", 64'(xfer_idx), 64'(LW - 1));
        end else begin
            chk("xfer_idx_idle", 64'(xfer_idx), 64'(m_idle_idx));
        end
        chk("ic_rvalid", 64'(ic_rvalid), 64'(e_ack && !m_side_d));
        chk("dc_rvalid", 64'(dc_rvalid), 64'(e_ack && m_side_d && !m_we));
        chk("dc_wready", 64'(dc_wready), 64'(e_ack && m_side_d && m_we));
        chk("ic_done", 64'(ic_done), 64'(e_done && !m_side_d));
        chk("dc_done", 64'(dc_done), 64'(e_done && m_side_d));
        if (e_ack && !m_side_d) chk("ic_rdata", 64'(ic_rdata), 64'(mem_rdata));
        if (e_ack && m_side_d && !m_we) chk("dc_rdata", 64'(dc_rdata), 64'(mem_rdata));

        obs_req = mem_req;
        obs_idx = xfer_idx;
        if (mem_req) begin
            addr_log.push_back(mem_addr);
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (ic_rvalid) begin
            ic_rv_cnt++;
            if (first_ic_beat < 0) first_ic_beat = cyc;
        end
        if (dc_rvalid || dc_wready) last_dc_beat = cyc;
        if (dc_wready) begin
            idx_log.push_back(int'(xfer_idx));
            if (mem_we) wr_we_cnt++;
        end
        if (ic_done) begin done_log.push_back(1'b0); done_cyc = cyc; end
        if (dc_done) begin done_log.push_back(1'b1); done_cyc = cyc; dc_done_cyc = cyc; end
    endtask

    task automatic model_update();
        bit d;
        if (rst) begin
            m_active   = 1'b0;
            m_idle_idx = 0;
            m_last_d   = 1'b0;
        end else if (!m_active) begin
            if (ic_req || dc_req) begin
                if (ic_req && dc_req) d = RR ? !m_last_d : 1'b1;
                else                  d = dc_req;
                m_side_d = d;
                m_last_d = d;
                m_we     = d && dc_we;
                m_base   = (d ? dc_addr : ic_addr) & ~32'(LW * 4 - 1);
                m_beats  = 0;
                m_active = 1'b1;
            end
        end else if (m_beats < LW) begin
            if (mem_ack) m_beats++;
        end else begin
            m_active   = 1'b0;
            m_idle_idx = LW - 1;
            if (m_side_d) dc_fin = 1'b1;
            else          ic_fin = 1'b1;
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next one.
    task automatic step();
        #1 compare();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_reqs();
        if (ic_fin) begin ic_req = 1'b0; ic_fin = 1'b0; end
        if (dc_fin) begin dc_req = 1'b0; dc_fin = 1'b0; end
        if (!ic_req && ic_want) begin ic_req = 1'b1; ic_addr = ic_next; end
        if (!dc_req && dc_want) begin dc_req = 1'b1; dc_addr = dc_next; dc_we = dc_next_we; end
        dc_wdata  = $urandom;
        mem_rdata = $urandom;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin drive_reqs(); step(); end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int found;
        rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        clear_obs();
        @(posedge clk);
        model_update();
        @(negedge clk);
        apply_reset(2);

        #1;
        chk("reset_mem_req", 64'(mem_req), 64'd0);
        chk("reset_mem_addr", 64'(mem_addr), 64'd0);
        chk("reset_xfer_idx", 64'(xfer_idx), 64'd0);
        chk("reset_strobes", 64'({ic_rvalid, dc_rvalid, dc_wready, ic_done, dc_done, mem_we}), 64'd0);

        // ICache refill alone, zero-wait memory; ack also held high across IDLE
        clear_obs();
        mem_ack = 1'b1; ic_want = 1'b1; ic_next = 32'h0000_1234;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin drive_reqs(); ic_want = 1'b0; step(); end
        chk("ic_beats", 64'(addr_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < addr_log.size(); i++)
            chk("ic_addr_seq", 64'(addr_log[i]), 64'(32'h1220 + 32'(4 * i)));
        chk("ic_rvalid_cnt", 64'(ic_rv_cnt), 64'd8);
        chk("ic_first_req_lat", 64'(first_req_cyc - c0), 64'd1);
        chk("ic_done_lat", 64'(done_cyc - c0), 64'd9);
        chk("ic_done_once", 64'(done_log.size()), 64'd1);

        // DCache write-back, memory acking every third cycle
        clear_obs();
        dc_want = 1'b1; dc_next = 32'h0000_2000; dc_next_we = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            mem_ack = ((cyc - c0) % 3 == 2);
            drive_reqs(); dc_want = 1'b0; step();
        end
        chk("wb_beats", 64'(idx_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < idx_log.size(); i++)
            chk("wb_idx_seq", 64'(idx_log[i]), 64'(i));
        chk("wb_mem_we", 64'(wr_we_cnt), 64'd8);
        chk("wb_done_after_last", 64'(dc_done_cyc - last_dc_beat), 64'd1);

        // Contention twice in succession, starting fresh from reset
        apply_reset(2);
        clear_obs();
        mem_ack = 1'b1;
        ic_want = 1'b1; ic_next = 32'h0000_4000;
        dc_want = 1'b1; dc_next = 32'h0000_8000; dc_next_we = 1'b0;
        for (int i = 0; i < 40 && done_log.size() < 2; i++) begin drive_reqs(); step(); end
        ic_want = 1'b0; dc_want = 1'b0;
        chk("contend_dones", 64'(done_log.size() >= 2), 64'd1);
        if (done_log.size() >= 2) begin
            chk("contend_first_d", 64'(done_log[0]), 64'd1);
            chk("contend_second", 64'(done_log[1]), 64'(RR ? 1'b0 : 1'b1));
        end
        for (int i = 0; i < 15; i++) begin drive_reqs(); step(); end

        // ICache request rising during a DCache line
        clear_obs();
        dc_want = 1'b1; dc_next = 32'h0000_C000; dc_next_we = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ic_want = (i == 4); ic_next = 32'h0000_5000;
            drive_reqs(); dc_want = 1'b0; step();
        end
        chk("mid_no_early_i", 64'(first_ic_beat > dc_done_cyc), 64'd1);
        chk("mid_gap_low", 64'(first_ic_beat - last_dc_beat - 1), 64'd2);

        // Reset during beat 3 of an ICache refill
        clear_obs();
        ic_want = 1'b1; ic_next = 32'h0000_7000;
        found = 0;
        for (int i = 0; i < 15 && found == 0; i++) begin
            drive_reqs(); ic_want = 1'b0; step();
            if (obs_req && obs_idx == IW'(2)) found = 1;
        end
        chk("rst_mid_reached", 64'(found), 64'd1);
        rst = 1'b1; drive_reqs(); step(); rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mid_idx", 64'(xfer_idx), 64'd0);
        chk("rst_mid_no_done", 64'(ic_done), 64'd0);
        addr_log.delete(); done_log.delete();
        for (int i = 0; i < 15; i++) begin drive_reqs(); step(); end
        chk("rst_restart_word0", 64'(addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF), 64'h7000);
        chk("rst_restart_done", 64'(done_log.size()), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            ic_want    = ($urandom_range(0, 3) == 0);
            dc_want    = ($urandom_range(0, 3) == 0);
            ic_next    = $urandom;
            dc_next    = $urandom;
            dc_next_we = 1'($urandom_range(0, 1));
            mem_ack    = ($urandom_range(0, 2) != 0);
            drive_reqs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
